// File: rtl/divisor_pkg.sv
// Shared types and elaboration helpers for the multi-cycle restoring divider.
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } estado_t;

  function automatic int num_iter(input int t, input int p);
    return t / p;
  endfunction

endpackage

// File: rtl/divisor_multiciclo_if.sv
// Start/Done handshake and operand/result bus of the multi-cycle divider.
interface divisor_multiciclo_if #(
  parameter int tamanyo = 32
);
  logic               Start;
  logic               Signo;
  logic [tamanyo-1:0] Num;
  logic [tamanyo-1:0] Den;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Res;
  logic               Done;
  logic               Div0;
  logic               Ready;

  modport master (output Start, Signo, Num, Den,
                  input  Coc, Res, Done, Div0, Ready);
  modport slave  (input  Start, Signo, Num, Den,
                  output Coc, Res, Done, Div0, Ready);
endinterface

// File: rtl/divisor_paso.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module divisor_paso #(
  parameter int tamanyo = 32
) (
  input  logic [tamanyo-1:0] rem,
  input  logic               bit_in,
  input  logic [tamanyo-1:0] den,
  output logic [tamanyo-1:0] rem_out,
  output logic               q
);
  logic [tamanyo:0] desp_s;
  logic [tamanyo:0] dif_s;

  // rem < den keeps the shifted value below 2*den, so bit tamanyo of the difference is the borrow
  always_comb begin
    desp_s = {rem, bit_in};
    dif_s  = desp_s - {1'b0, den};
    if (dif_s[tamanyo] == 1'b0) begin
      q       = 1'b1;
      rem_out = dif_s[tamanyo-1:0];
    end else begin
      q       = 1'b0;
      rem_out = desp_s[tamanyo-1:0];
    end
  end
endmodule

// File: rtl/divisor_multiciclo.sv
// Multi-cycle restoring divider: pasos quotient bits per clock, signed/unsigned per operation.
module divisor_multiciclo
  import divisor_pkg::*;
#(
  parameter int tamanyo = 32,
  parameter int pasos   = 1
) (
  input  logic                 CLK,
  input  logic                 RSTa,
  divisor_multiciclo_if.slave  bus
);
  localparam int N  = num_iter(tamanyo, pasos);
  localparam int CW = $clog2(N + 1);

  if ((pasos != 1 && pasos != 2) || (tamanyo % pasos) != 0 || tamanyo < 4 || (tamanyo % 2) != 0) begin : g_param_err
    $error("divisor_multiciclo: illegal tamanyo/pasos combination");
  end

  estado_t            estado_r, estado_s;
  logic [CW-1:0]      cnt_r;
  logic [tamanyo-1:0] rem_r, dvd_r, den_r;
  logic               sq_r, sr_r, div0_r;
  logic [tamanyo-1:0] coc_r, res_r;
  logic               done_r, div0o_r, ready_r;

  logic [tamanyo-1:0] num_abs_s, den_abs_s;
  logic               den_cero_s;
  logic [tamanyo-1:0] rem_c [pasos+1];
  logic [tamanyo-1:0] dvd_c [pasos+1];
  logic [pasos-1:0]   q_c;

  assign den_cero_s = (bus.Den == {tamanyo{1'b0}});
  assign num_abs_s  = (bus.Signo && bus.Num[tamanyo-1]) ? (~bus.Num + tamanyo'(1)) : bus.Num;
  assign den_abs_s  = (bus.Signo && bus.Den[tamanyo-1]) ? (~bus.Den + tamanyo'(1)) : bus.Den;

  // dvd_r doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
  assign rem_c[0] = rem_r;
  assign dvd_c[0] = dvd_r;
  for (genvar g = 0; g < pasos; g++) begin : g_paso
    divisor_paso #(.tamanyo(tamanyo)) u_paso (
      .rem     (rem_c[g]),
      .bit_in  (dvd_c[g][tamanyo-1]),
      .den     (den_r),
      .rem_out (rem_c[g+1]),
      .q       (q_c[g])
    );
    assign dvd_c[g+1] = {dvd_c[g][tamanyo-2:0], q_c[g]};
  end

  // State register
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) estado_r <= IDLE;
    else      estado_r <= estado_s;
  end

  // Next-state decode
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      IDLE: begin
        if (bus.Start) begin
          if (den_cero_s) estado_s = FIX;
          else            estado_s = CALC;
        end else begin
          estado_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CW'(1)) estado_s = FIX;
        else                 estado_s = CALC;
      end
      FIX:     estado_s = IDLE;
      default: estado_s = IDLE;
    endcase
  end

  // Operand capture, iteration and sign fix-up
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      cnt_r   <= {CW{1'b0}};
      rem_r   <= {tamanyo{1'b0}};
      dvd_r   <= {tamanyo{1'b0}};
      den_r   <= {tamanyo{1'b0}};
      sq_r    <= 1'b0;
      sr_r    <= 1'b0;
      div0_r  <= 1'b0;
      coc_r   <= {tamanyo{1'b0}};
      res_r   <= {tamanyo{1'b0}};
      div0o_r <= 1'b0;
    end else begin
      case (estado_r)
        IDLE: begin
          if (bus.Start) begin
            sq_r   <= bus.Signo & (bus.Num[tamanyo-1] ^ bus.Den[tamanyo-1]);
            sr_r   <= bus.Signo & bus.Num[tamanyo-1];
            rem_r  <= {tamanyo{1'b0}};
            cnt_r  <= CW'(N);
            div0_r <= den_cero_s;
            den_r  <= den_abs_s;
            // a zero divisor reports the untouched dividend as remainder
            dvd_r  <= den_cero_s ? bus.Num : num_abs_s;
          end
        end
        CALC: begin
          rem_r <= rem_c[pasos];
          dvd_r <= dvd_c[pasos];
          cnt_r <= cnt_r - CW'(1);
        end
        FIX: begin
          if (div0_r) begin
            coc_r   <= {tamanyo{1'b1}};
            res_r   <= dvd_r;
            div0o_r <= 1'b1;
          end else begin
            coc_r   <= sq_r ? (~dvd_r + tamanyo'(1)) : dvd_r;
            res_r   <= sr_r ? (~rem_r + tamanyo'(1)) : rem_r;
            div0o_r <= 1'b0;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Done pulse and Ready flag, registered from the state transition
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      done_r  <= (estado_r == FIX);
      ready_r <= (estado_s == IDLE);
    end
  end

  assign bus.Coc   = coc_r;
  assign bus.Res   = res_r;
  assign bus.Done  = done_r;
  assign bus.Div0  = div0o_r;
  assign bus.Ready = ready_r;
endmodule

// File: doc/divisor_multiciclo.md
# divisor_multiciclo

Parametrised multi-cycle restoring divider, the successor of the team's fixed-mode algorithmic divider. Adds per-operation signed/unsigned mode, a configurable number of quotient bits retired per clock, divide-by-zero detection and an explicit ready indication. It sits behind any datapath master that issues a Start pulse and waits for Done; operands are captured at Start, and results are held stable until the next accepted Start.

## Interface
- tamanyo, 32, operand/result width in bits (≥ 4, even)
- pasos, 1, quotient bits per clock (1 or 2); tamanyo % pasos == 0
- N (derived localparam) = tamanyo/pasos, number of iteration cycles

- CLK  in  1  clock; all state updates on the rising edge
- RSTa  in  1  asynchronous, active-high reset
- Start  in  1  request; sampled only when Ready=1
- Signo  in  1  1 = two's-complement operands/results, 0 = unsigned; captured with Start
- Num  in  tamanyo  dividend; captured with Start
- Den  in  tamanyo  divisor; captured with Start
- Coc  out  tamanyo  quotient; reset value 0
- Res  out  tamanyo  remainder; reset value 0
- Done  out  1  one-cycle pulse, results valid; reset value 0
- Div0  out  1  last result was a divide by zero; valid with Coc/Res; reset value 0
- Ready  out  1  state==IDLE; reset value 1

## Operation
- States: IDLE, CALC, FIX. Reset -> IDLE, all outputs as listed above, iteration counter 0.
- IDLE & Start: latch Signo. If Signo, store |Num| and |Den| plus the sign flags sq = Num[msb]^Den[msb] and sr = Num[msb]; otherwise store the raw values. Clear the partial remainder, load the counter with N, and go to CALC. Zero divisor: go directly to FIX with the div0 flag set.
- CALC: each cycle performs pasos restoring steps in cascade. Each step shifts the remainder/dividend pair left by 1, trial-subtracts the divisor on a (tamanyo+1)-bit path, and sets the quotient bit if the result is non-negative. The counter decrements; when it reaches 1, go to FIX.
- FIX: apply the sign correction when Signo=1. Negate the quotient if sq; negate the remainder if sr. Register Coc, Res and Div0, pulse Done, and go to IDLE.
- Semantics: truncation toward zero; the remainder takes the sign of the dividend (Num = Coc*Den + Res).
- Divide by zero: Coc = all ones, Res = Num (unmodified), Div0 = 1, in both modes.
- Signed overflow (most-negative / −1): Coc = most-negative value, Res = 0, Div0 = 0. This is the natural result of the wrap.
- Start while Ready=0 is ignored; no queueing.
- Coc, Res and Div0 change only in FIX; they hold between operations.

## Timing
- Start sampled at edge 0 (IDLE). The N iteration edges are 1..N. FIX executes at edge N+1; Done is high for the cycle following edge N+1. Latency = N+1 cycles from Start sample to Done.
- Divide by zero: FIX executes at edge 1, so Done is high after edge 1 (latency 1).
- Ready is low from edge 0 until edge N+1, and returns high in the same cycle as Done. A Start presented during the Done cycle is accepted (back-to-back throughput = N+1 cycles).
- Done falls at the next edge regardless of Start.
- RSTa asserted mid-operation: immediate return to IDLE, outputs to reset values, and no Done for the aborted operation. The first Start after deassertion is accepted normally.

## Structure
- Package divisor_pkg holds the state enum (IDLE, CALC, FIX) and the helper function for the N computation.
- Sub-module divisor_paso: a combinational single restoring step (inputs: remainder, dividend bit, divisor; outputs: new remainder, quotient bit). It is instantiated pasos times in a generate chain.
- Parameter legality (pasos ∈ {1,2}, divisibility) is checked by an elaboration-time assertion.

## Test plan
- tamanyo=8, pasos=1, Signo=0, Num=200, Den=7 -> after 9 cycles Done=1, Coc=28, Res=4, Div0=0; Ready low for exactly 9 cycles.
- tamanyo=8, pasos=2, Signo=1: Num=−7, Den=2 -> Coc=−3, Res=−1 after 5 cycles. Then Num=7, Den=−2 -> Coc=−3, Res=1. Then Num=−128, Den=−1 -> Coc=−128, Res=0.
- Den=0, Num=0x5A, either mode -> Done after 1 cycle, Coc=0xFF, Res=0x5A, Div0=1. The next valid operation clears Div0.
- Start held high continuously for three operations -> Done pulses exactly N+1 cycles apart; operand changes while Ready=0 do not affect results.
- RSTa pulsed at cycle 4 of a pasos=1 operation -> Coc=Res=0, Done never pulses for it, Ready=1; a new Start then completes correctly.
- Randomised self-check, tamanyo=32, both pasos, both modes -> Coc/Res equal the SystemVerilog / and % results on the same operands (zero divisor excluded).
